// File: rtl/dds_pkg.sv
// Shared definitions for the multi-channel DDS sine generator:
// channel-index width, quadrant codes and the quarter-wave table generator.
package dds_pkg;

  localparam logic [1:0] Q0 = 2'b00;
  localparam logic [1:0] Q1 = 2'b01;
  localparam logic [1:0] Q2 = 2'b10;
  localparam logic [1:0] Q3 = 2'b11;

  function automatic int calc_chw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Entry i of a 2^aw quarter-wave table with dw-bit signed full scale.
  // sin() is a Taylor series so the table folds to constants at elaboration.
  function automatic int rom_entry(input int i, input int aw, input int dw);
    real two_a;
    real amp;
    real x;
    real term;
    real s;
    two_a = 1.0;
    for (int k = 0; k < aw; k++) two_a = two_a * 2.0;
    amp = 1.0;
    for (int k = 0; k < dw - 1; k++) amp = amp * 2.0;
    amp = amp - 1.0;
    x = 1.57079632679489662 * (real'(i) + 0.5) / two_a;
    term = x;
    s = x;
    for (int k = 1; k <= 12; k++) begin
      term = -term * x * x / real'((2 * k) * (2 * k + 1));
      s = s + term;
    end
    return $rtoi(amp * s + 0.5);
  endfunction

endpackage

// File: rtl/dds_sine_mc_rom.sv
// Quarter-wave sine magnitude ROM, one registered read per cycle.
// Contents are fixed at elaboration; the read register has no reset.
module quarter_sine_rom
  import dds_pkg::*;
#(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-2:0] dout
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int MAG_W = DATA_WIDTH - 1;

  logic [MAG_W-1:0] rom [DEPTH];
  logic [MAG_W-1:0] dout_d;
  logic [MAG_W-1:0] dout_q;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_rom
      assign rom[gi] = MAG_W'(rom_entry(gi, ADDR_WIDTH, DATA_WIDTH));
    end
  endgenerate

  always_comb dout_d = rom[addr];

  always_ff @(posedge clk) dout_q <= dout_d;

  assign dout = dout_q;

endmodule

// File: rtl/dds_sine_mc.sv
// Multi-channel DDS: per-channel phase accumulators, round-robin issue into
// a shared quarter-wave ROM, and a tagged signed sample stream 2 cycles later.
module dds_sine_mc
  import dds_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int PHASE_WIDTH = 16,
  parameter int ADDR_WIDTH  = 7,
  parameter int DATA_WIDTH  = 16,
  parameter int INCR_WIDTH  = 16,
  localparam int CHW        = calc_chw(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         updn,
  input  logic                         preload,
  input  logic [CHW-1:0]               pl_ch,
  input  logic [PHASE_WIDTH-1:0]       pl_phase,
  input  logic                         incr_we,
  input  logic [CHW-1:0]               incr_ch,
  input  logic [INCR_WIDTH-1:0]        incr_data,
  output logic signed [DATA_WIDTH-1:0] sine_out,
  output logic [CHW-1:0]               sine_ch,
  output logic                         sine_valid
);

  localparam int P     = PHASE_WIDTH;
  localparam int A     = ADDR_WIDTH;
  localparam int LW    = A + 2;
  localparam int MAG_W = DATA_WIDTH - 1;

  logic [LW-1:0]  look_all [NUM_CH];
  logic [CHW-1:0] sel_q, sel_d;

  // Per-channel state; only the top quadrant+index bits leave the channel.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [P-1:0] ph_q, ph_d;
      logic [P-1:0] inc_q, inc_d;
      logic         issue, pl_hit, inc_hit;

      always_comb begin
        issue   = enable && (sel_q == CHW'(gi));
        pl_hit  = preload && (pl_ch == CHW'(gi));
        inc_hit = incr_we && (incr_ch == CHW'(gi));
        ph_d    = ph_q;
        if (pl_hit)     ph_d = pl_phase;
        else if (issue) ph_d = updn ? ph_q + inc_q : ph_q - inc_q;
        inc_d = inc_hit ? P'(incr_data) : inc_q;
      end

      always_ff @(posedge clk) begin
        if (!reset) begin
          ph_q  <= '0;
          inc_q <= '0;
        end else begin
          ph_q  <= ph_d;
          inc_q <= inc_d;
        end
      end

      assign look_all[gi] = ph_q[P-1 -: LW];
    end
  endgenerate

  logic [LW-1:0]      look;
  logic [1:0]         quad;
  logic [A-1:0]       idx;
  logic               s1_valid_q, s1_valid_d;
  logic [A-1:0]       s1_addr_q, s1_addr_d;
  logic [1:0]         s1_quad_q, s1_quad_d;
  logic [CHW-1:0]     s1_ch_q, s1_ch_d;
  logic               s2_valid_q, s2_valid_d;
  logic [1:0]         s2_quad_q, s2_quad_d;
  logic [CHW-1:0]     s2_ch_q, s2_ch_d;
  logic [MAG_W-1:0]   rom_dout;
  logic [DATA_WIDTH-1:0] mag_ext;
  logic signed [DATA_WIDTH-1:0] sine_out_q, sine_out_d;
  logic [CHW-1:0]     sine_ch_q, sine_ch_d;
  logic               sine_valid_q, sine_valid_d;

  always_comb begin
    look = look_all[sel_q];
    quad = look[LW-1 -: 2];
    idx  = look[A-1:0];

    sel_d = sel_q;
    if (enable) sel_d = (sel_q == CHW'(NUM_CH - 1)) ? '0 : sel_q + CHW'(1);

    // Odd quadrants read the table backwards.
    s1_valid_d = enable;
    s1_addr_d  = ((quad == Q1) || (quad == Q3)) ? ~idx : idx;
    s1_quad_d  = quad;
    s1_ch_d    = sel_q;

    s2_valid_d = s1_valid_q;
    s2_quad_d  = s1_quad_q;
    s2_ch_d    = s1_ch_q;

    mag_ext      = {1'b0, rom_dout};
    sine_valid_d = s2_valid_q;
    sine_out_d   = sine_out_q;
    sine_ch_d    = sine_ch_q;
    if (s2_valid_q) begin
      sine_out_d = ((s2_quad_q == Q2) || (s2_quad_q == Q3)) ? -mag_ext : mag_ext;
      sine_ch_d  = s2_ch_q;
    end
  end

  quarter_sine_rom #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_rom (
    .clk (clk),
    .addr(s1_addr_q),
    .dout(rom_dout)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      sel_q        <= '0;
      s1_valid_q   <= 1'b0;
      s1_addr_q    <= '0;
      s1_quad_q    <= '0;
      s1_ch_q      <= '0;
      s2_valid_q   <= 1'b0;
      s2_quad_q    <= '0;
      s2_ch_q      <= '0;
      sine_out_q   <= '0;
      sine_ch_q    <= '0;
      sine_valid_q <= 1'b0;
    end else begin
      sel_q        <= sel_d;
      s1_valid_q   <= s1_valid_d;
      s1_addr_q    <= s1_addr_d;
      s1_quad_q    <= s1_quad_d;
      s1_ch_q      <= s1_ch_d;
      s2_valid_q   <= s2_valid_d;
      s2_quad_q    <= s2_quad_d;
      s2_ch_q      <= s2_ch_d;
      sine_out_q   <= sine_out_d;
      sine_ch_q    <= sine_ch_d;
      sine_valid_q <= sine_valid_d;
    end
  end

  assign sine_out   = sine_out_q;
  assign sine_ch    = sine_ch_q;
  assign sine_valid = sine_valid_q;

endmodule

// File: tb/tb_dds_sine_mc.sv
// Scoreboard bench for dds_sine_mc: directed vectors push hand-computed
// samples with their due cycle; a negedge monitor pops and compares.
module tb_dds_sine_mc;

  localparam int NCH = 4;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               enable = 1'b0;
  logic               updn = 1'b1;
  logic               preload = 1'b0;
  logic [1:0]         pl_ch = '0;
  logic [15:0]        pl_phase = '0;
  logic               incr_we = 1'b0;
  logic [1:0]         incr_ch = '0;
  logic [15:0]        incr_data = '0;
  logic signed [15:0] sine_out;
  logic [1:0]         sine_ch;
  logic               sine_valid;

  dds_sine_mc #(
    .NUM_CH(NCH), .PHASE_WIDTH(16), .ADDR_WIDTH(7), .DATA_WIDTH(16), .INCR_WIDTH(16)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .updn(updn),
    .preload(preload), .pl_ch(pl_ch), .pl_phase(pl_phase),
    .incr_we(incr_we), .incr_ch(incr_ch), .incr_data(incr_data),
    .sine_out(sine_out), .sine_ch(sine_ch), .sine_valid(sine_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         stamp;
    logic [1:0] ch;
    int         val;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  logic [1:0] sel_m = '0;
  int         hold_val = 0;
  logic [1:0] hold_ch = '0;
  bit         armed = 1'b0;
  bit         ud_g = 1'b1;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input integer act, input integer expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, expv, cyc);
    end
  endtask

  // Monitor: every valid sample must match the oldest expectation and its due cycle.
  initial forever begin
    @(negedge clk);
    if (armed) begin
      if (sine_valid === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_sample: got ch %0d value %0d, expected none at cycle %0d",
                   sine_ch, sine_out, cyc);
        end else begin
          mon_e = sb.pop_front();
          chk("sample_cycle", cyc, mon_e.stamp);
          chk("sample_ch", sine_ch, mon_e.ch);
          chk("sample_value", sine_out, mon_e.val);
          hold_val = mon_e.val;
          hold_ch  = mon_e.ch;
        end
      end else begin
        if (sb.size() > 0 && sb[0].stamp <= cyc) begin
          checks++;
          failures++;
          $display("FAIL missing_sample: got valid=%0d expected ch %0d value %0d at cycle %0d",
                   sine_valid, sb[0].ch, sb[0].val, cyc);
          void'(sb.pop_front());
        end
        chk("hold_value", sine_out, hold_val);
        chk("hold_ch", sine_ch, hold_ch);
      end
    end
  end

  // One cycle of stimulus; an issued lookup is due 3 counts later (2 cycles after its edge).
  task automatic v(input bit en, input bit pl, input logic [1:0] plc, input logic [15:0] plp,
                   input bit iw, input logic [1:0] ic, input logic [15:0] id, input int expv);
    exp_t e;
    enable = en; updn = ud_g; preload = pl; pl_ch = plc; pl_phase = plp;
    incr_we = iw; incr_ch = ic; incr_data = id;
    if (en) begin
      e.stamp = cyc + 3;
      e.ch    = sel_m;
      e.val   = expv;
      sb.push_back(e);
      sel_m = (sel_m == 2'(NCH - 1)) ? 2'd0 : sel_m + 2'd1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic iss(input int expv);
    v(1'b1, 1'b0, 2'd0, 16'h0000, 1'b0, 2'd0, 16'h0000, expv);
  endtask

  task automatic idle();
    v(1'b0, 1'b0, 2'd0, 16'h0000, 1'b0, 2'd0, 16'h0000, 0);
  endtask

  task automatic do_reset();
    reset = 1'b0; enable = 1'b1; preload = 1'b0; incr_we = 1'b0;
    @(posedge clk);
    #1;
    sb.delete();
    sel_m = '0; hold_val = 0; hold_ch = '0;
    chk("reset_valid", sine_valid, 0);
    chk("reset_out", sine_out, 0);
    chk("reset_ch", sine_ch, 0);
    reset = 1'b1; enable = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("init_valid", sine_valid, 0);
    chk("init_out", sine_out, 0);
    chk("init_ch", sine_ch, 0);
    armed = 1'b1;
    reset = 1'b1;

    // all phases and increments zero: rom[0] on every channel
    repeat (8) iss(201);

    // preloads during idle cycles; inc write on the issuing channel takes effect next time
    v(1'b0, 1'b1, 2'd1, 16'h4000, 1'b0, 2'd0, 16'h0000, 0);
    v(1'b0, 1'b1, 2'd2, 16'hC000, 1'b0, 2'd0, 16'h0000, 0);
    iss(201); iss(32766); iss(-32766);
    v(1'b1, 1'b0, 2'd0, 16'h0000, 1'b1, 2'd3, 16'h0080, 201);
    iss(201); iss(32766); iss(-32766); iss(201);
    v(1'b1, 1'b1, 2'd1, 16'h4080, 1'b0, 2'd0, 16'h0000, 201);
    iss(32761); iss(-32766); iss(603);

    // wrap up from 0xFF00, then down from 0x0000
    v(1'b1, 1'b1, 2'd2, 16'h8000, 1'b1, 2'd0, 16'h0100, 201);
    v(1'b1, 1'b1, 2'd0, 16'hFF00, 1'b0, 2'd0, 16'h0000, 32761);
    v(1'b1, 1'b1, 2'd3, 16'h3F80, 1'b1, 2'd3, 16'h0000, -201);
    iss(32766);
    iss(-603); iss(32761); iss(-201); iss(32766);
    ud_g = 1'b0;
    iss(201); iss(32761); iss(-201); iss(32766);
    ud_g = 1'b1;
    iss(-603); iss(32761); iss(-201); iss(32766);

    // preload beats accumulate on the issuing channel
    v(1'b1, 1'b1, 2'd0, 16'h8000, 1'b0, 2'd0, 16'h0000, 201);
    iss(32761); iss(-201); iss(32766);
    iss(-201);
    v(1'b1, 1'b1, 2'd0, 16'h0000, 1'b1, 2'd0, 16'h0000, 32761);
    iss(-201); iss(32766);

    // enable gaps: sel and phases freeze, outputs hold
    iss(201); idle(); idle(); iss(32761); iss(-201); idle(); iss(32766);

    // reset with a full pipeline; increments and phases must clear
    v(1'b1, 1'b0, 2'd0, 16'h0000, 1'b1, 2'd1, 16'h0080, 201);
    iss(32761); iss(-201);
    do_reset();
    repeat (8) iss(201);

    repeat (4) idle();
    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dds_sine_mc.md
Name: dds_sine_mc

Overview:
Multi-channel direct digital synthesis sine generator. It is the successor to the single-channel address-counter and sine-ROM block. Each of NUM_CH channels has its own fractional phase accumulator and increment register. The channels share one quarter-wave ROM through a round-robin time-multiplexed 3-stage pipeline, which produces a tagged signed sine sample stream for downstream mixers and DACs.

Parameters:
NUM_CH, 4, number of channels (>=1)
PHASE_WIDTH, 16, accumulator width P; must satisfy P >= ADDR_WIDTH+2
ADDR_WIDTH, 7, quarter-wave ROM address width A (2^A entries)
DATA_WIDTH, 16, signed output sample width
INCR_WIDTH, 16, increment width; zero-extended to P, and must be <= P

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
enable  in  1  1 = issue one channel lookup this cycle
updn  in  1  1 = accumulate up (+inc), 0 = down (-inc); global to all channels
preload  in  1  load pl_phase into channel pl_ch
pl_ch  in  CHW=max(1,$clog2(NUM_CH))  preload channel index
pl_phase  in  PHASE_WIDTH  preload phase value
incr_we  in  1  write incr_data into channel incr_ch
incr_ch  in  CHW  increment channel index
incr_data  in  INCR_WIDTH  increment value
sine_out  out  DATA_WIDTH  signed sample, two's complement, registered
sine_ch  out  CHW  channel of sine_out
sine_valid  out  1  sine_out/sine_ch valid this cycle

Behaviour:
- Reset (reset==0 at posedge) clears the following; it overrides all other inputs in that cycle:
  - ph[*], inc[*], sel, all pipeline valid bits and data;
  - outputs: sine_out=0, sine_ch=0, sine_valid=0.
- Issue, edge E0, when enable=1, with c = sel:
  - quadrant q = ph[c][P-1:P-2]; idx = ph[c][P-3:P-2-A];
  - ROM address = q[0] ? ~idx : idx; q and c are registered alongside the address;
  - ph[c] <= ph[c] +/- inc[c], modulo 2^P, so wrap-around is silent;
  - sel <= (sel==NUM_CH-1) ? 0 : sel+1.
- Idle: enable=0 means no issue, sel holds, and ph holds. The pipeline keeps draining: a bubble propagates as valid=0.
- ROM stage, edge E1: 1-cycle registered read, mag = rom[addr], unsigned DATA_WIDTH-1 bits.
- Output stage, edge E2: sine_out <= q[1] ? -mag : mag; sine_ch <= c; sine_valid <= stage valid.
- Latency: a sample issued at E0 is presented after E2, i.e. 2 cycles.
- Throughput: one sample per enabled cycle. Each channel updates once per NUM_CH enabled cycles.
- sine_valid=0 cycles: sine_out and sine_ch hold their last values.
- ROM contents: rom[i] = round((2^(DATA_WIDTH-1)-1) * sin(pi/2*(i+0.5)/2^A)). The half-sample offset gives exact quadrant symmetry. Negation can never overflow.
- Preload: ph[pl_ch] <= pl_phase.
  - If the same channel is issued in the same cycle, preload wins over accumulate, and that issued lookup uses the pre-load phase.
  - If pl_ch >= NUM_CH, preload is ignored.
- Increment write: inc[incr_ch] <= zero-extended incr_data.
  - If the channel is issued in the same cycle, accumulate uses the old inc; the new value applies from its next issue.
  - If incr_ch >= NUM_CH, the write is ignored.
- preload and incr_we may be asserted together, to the same or different channels; they are independent.
- Reset mid-stream: in-flight samples are discarded and no partial output appears. The first valid sample appears 2 cycles after the first enabled issue following reset release, starting at channel 0.

Decomposition:
- Package dds_pkg:
  - CHW computation function;
  - quadrant encoding constants Q0..Q3;
  - ROM table generation function (sin formula above), used for initialisation.
- Sub-module quarter_sine_rom (params ADDR_WIDTH, DATA_WIDTH):
  - ports clk, addr, dout;
  - synchronous read, 1-cycle latency, no reset.
- The top level holds the accumulator arrays, the scheduler, and the pipeline registers.

Test Plan:
1. Reset, then enable=1 continuously, all inc=0 -> from cycle 2, sine_valid=1 every cycle; sine_ch sequence 0,1,2,3,0...; sine_out=rom[0]=201 (defaults).
2. preload ch1 with 0x4000 (q=1, idx=0 -> addr 127) -> ch1 samples = rom[127]=32766. preload ch2 with 0xC000 -> ch2 samples = -32766.
3. incr_we ch0=0x0100, updn=1, preload ch0=0xFF00 -> the next ch0 issue uses phase 0xFF00, and ph0 then wraps to 0x0000. With updn=0 from 0x0000, ph0 becomes 0xFF00.
4. Same cycle: preload ch0=0x8000 and ch0 issued with inc=0x0100 and phase 0x1000 -> that output uses 0x1000; the following ch0 issue uses 0x8000 (output -rom[0]=-201), not 0x8100.
5. enable toggled 1,0,0,1 -> sine_valid follows the same pattern delayed by 2 cycles; sel and ph frozen during the gaps; sine_out holds during invalid cycles.
6. reset low for one cycle while the pipeline is full -> next cycle sine_valid=0, sine_out=0, sine_ch=0; after release, the first issue is ch0 with phase 0.
